// File: rtl/regfile_bypass_sb.sv
// Decode-stage register file: NREGS registers plus a PC alias, two write ports
// with same-cycle bypass into three read ports, and a pending-write scoreboard.
module regfile_bypass_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NREGS  = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wd2,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_wa,
    output logic              busy1,
    output logic              busy2,
    output logic              busy3,
    output logic              stall
);

    localparam logic [ADDR_W-1:0] PC_ADDR = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];
    logic [NREGS-1:0]  pending_q;
    logic [NREGS-1:0]  pending_d;

    // PC_ADDR is never below NREGS, so this also excludes the PC alias.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (32'(a) < NREGS);
    endfunction

    logic w1_ok, w2_ok, iss_ok;

    always_comb begin
        w1_ok  = we1 && in_range(wa1);
        w2_ok  = we2 && in_range(wa2);
        iss_ok = iss_en && in_range(iss_wa);
    end

    // Port 2 is applied first so port 1 overrides it on an address collision.
    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            rf_d[i] = rf_q[i];
        end
        if (w2_ok) rf_d[wa2] = wd2;
        if (w1_ok) rf_d[wa1] = wd1;
    end

    // Retiring writes clear their bit; a new issue to the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (w2_ok)  pending_d[wa2]    = 1'b0;
        if (w1_ok)  pending_d[wa1]    = 1'b0;
        if (iss_ok) pending_d[iss_wa] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf_q[i] <= rf_d[i];
            end
            pending_q <= pending_d;
        end
    end

    logic [ADDR_W-1:0] raddr [3];
    logic [DATA_W-1:0] rdata [3];
    logic              rbusy [3];

    always_comb begin
        raddr[0] = a1;
        raddr[1] = a2;
        raddr[2] = a3;
    end

    // A write landing this cycle feeds the reader directly, so it never stalls.
    for (genvar p = 0; p < 3; p++) begin : g_read
        logic hit1, hit2, valid;

        always_comb begin
            valid    = in_range(raddr[p]);
            hit1     = w1_ok && (wa1 == raddr[p]);
            hit2     = w2_ok && (wa2 == raddr[p]);
            rdata[p] = '0;
            rbusy[p] = 1'b0;
            if (raddr[p] == PC_ADDR) begin
                rdata[p] = pc_in;
            end else if (valid) begin
                if (hit1)      rdata[p] = wd1;
                else if (hit2) rdata[p] = wd2;
                else           rdata[p] = rf_q[raddr[p]];
                rbusy[p] = pending_q[raddr[p]] && !hit1 && !hit2;
            end
        end
    end

    always_comb begin
        rd1   = rdata[0];
        rd2   = rdata[1];
        rd3   = rdata[2];
        busy1 = rbusy[0];
        busy2 = rbusy[1];
        busy3 = rbusy[2];
        stall = rbusy[0] | rbusy[1] | rbusy[2];
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: reset contents, bypass, port priority,
// PC alias, scoreboard set/clear and reset clearing of pending bits.
module tb_regfile_bypass_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        we1, we2, iss_en;
    logic [3:0]  wa1, wa2, a1, a2, a3, iss_wa;
    logic [31:0] wd1, wd2, pc_in;
    logic [31:0] rd1, rd2, rd3;
    logic        busy1, busy2, busy3, stall;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rf [16];

    regfile_bypass_sb dut (
        .clk(clk), .reset(reset),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .we2(we2), .wa2(wa2), .wd2(wd2),
        .pc_in(pc_in),
        .a1(a1), .a2(a2), .a3(a3),
        .rd1(rd1), .rd2(rd2), .rd3(rd3),
        .iss_en(iss_en), .iss_wa(iss_wa),
        .busy1(busy1), .busy2(busy2), .busy3(busy3),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then leave the inputs a settling gap.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        we1 = 0; we2 = 0; iss_en = 0;
    endtask

    initial begin
        reset = 1; idle_writes();
        wa1 = 0; wa2 = 0; wd1 = 0; wd2 = 0; iss_wa = 0;
        a1 = 0; a2 = 0; a3 = 0; pc_in = 32'h0000_0100;
        for (int i = 0; i < 16; i++) exp_rf[i] = 32'h0;
        exp_rf[15] = 32'h100;
        // Writes and issues during reset must be ignored.
        we1 = 1; wa1 = 2; wd1 = 32'h1234; iss_en = 1; iss_wa = 2;
        tick();
        idle_writes();
        tick();
        reset = 0;
        #1;

        for (int i = 0; i < 16; i++) begin
            a1 = 4'(i); a2 = 4'(i); a3 = 4'(i);
            #1;
            check($sformatf("reset_rd1_r%0d", i), rd1, exp_rf[i]);
            check($sformatf("reset_rd3_r%0d", i), rd3, exp_rf[i]);
            check($sformatf("reset_busy_r%0d", i), {29'b0, busy1, busy2, busy3}, 32'h0);
            check($sformatf("reset_stall_r%0d", i), {31'b0, stall}, 32'h0);
        end

        // Port 1 write with same-cycle bypass, then stored value.
        we1 = 1; wa1 = 3; wd1 = 32'hDEAD_BEEF; a1 = 3;
        #1;
        check("bypass_w1_r3", rd1, 32'hDEAD_BEEF);
        tick();
        idle_writes();
        #1;
        check("stored_r3", rd1, 32'hDEAD_BEEF);
        exp_rf[3] = 32'hDEAD_BEEF;

        // Dual write to r5: port 1 wins.
        we1 = 1; wa1 = 5; wd1 = 32'h1; we2 = 1; wa2 = 5; wd2 = 32'h2; a2 = 5;
        #1;
        check("dual_bypass_r5", rd2, 32'h1);
        tick();
        idle_writes();
        #1;
        check("dual_stored_r5", rd2, 32'h1);
        exp_rf[5] = 32'h1;

        we2 = 1; wa2 = 6; wd2 = 32'h7; a3 = 6;
        #1;
        check("bypass_w2_r6", rd3, 32'h7);
        tick();
        idle_writes();
        #1;
        check("stored_r6", rd3, 32'h7);
        exp_rf[6] = 32'h7;

        // Write to PC alias is dropped, read returns pc_in.
        we1 = 1; wa1 = 15; wd1 = 32'hFFFF_FFFF; a2 = 15;
        #1;
        check("pc_read_during_w", rd2, 32'h100);
        check("pc_busy2", {31'b0, busy2}, 32'h0);
        tick();
        idle_writes();
        pc_in = 32'h0000_0200; exp_rf[15] = 32'h200;
        for (int i = 0; i < 16; i++) begin
            a1 = 4'(i);
            #1;
            check($sformatf("after_pcw_r%0d", i), rd1, exp_rf[i]);
        end

        // Issuing to the PC alias never marks anything busy.
        iss_en = 1; iss_wa = 15;
        tick();
        idle_writes();
        a1 = 15;
        #1;
        check("pc_issue_busy", {31'b0, busy1}, 32'h0);

        // Scoreboard: issue r4, busy until its writeback.
        iss_en = 1; iss_wa = 4; a1 = 4; a2 = 4; a3 = 1;
        #1;
        check("iss_same_cycle_busy", {31'b0, busy1}, 32'h0);
        tick();
        idle_writes();
        #1;
        check("pend_busy1", {31'b0, busy1}, 32'h1);
        check("pend_busy2", {31'b0, busy2}, 32'h1);
        check("pend_busy3_other", {31'b0, busy3}, 32'h0);
        check("pend_stall", {31'b0, stall}, 32'h1);
        tick();
        check("pend_hold_busy1", {31'b0, busy1}, 32'h1);
        we1 = 1; wa1 = 4; wd1 = 32'h55;
        #1;
        check("wb_busy1", {31'b0, busy1}, 32'h0);
        check("wb_stall", {31'b0, stall}, 32'h0);
        check("wb_rd1", rd1, 32'h55);
        tick();
        idle_writes();
        #1;
        check("post_wb_busy1", {31'b0, busy1}, 32'h0);
        check("post_wb_rd1", rd1, 32'h55);

        // Set and clear of r7 in one cycle: set wins.
        iss_en = 1; iss_wa = 7; we2 = 1; wa2 = 7; wd2 = 32'h9; a1 = 7; a2 = 0; a3 = 0;
        tick();
        idle_writes();
        #1;
        check("setwin_busy1", {31'b0, busy1}, 32'h1);
        check("setwin_rd1", rd1, 32'h9);
        we2 = 1; wa2 = 7; wd2 = 32'hB;
        #1;
        check("w2_bypass_unbusy", {31'b0, busy1}, 32'h0);
        check("w2_bypass_rd1", rd1, 32'hB);
        we2 = 0;
        #1;
        check("w2_removed_busy", {31'b0, busy1}, 32'h1);

        // Reset clears pending and data; bypass still works while reset is high.
        reset = 1; we1 = 1; wa1 = 7; wd1 = 32'hAA;
        #1;
        check("reset_bypass_rd1", rd1, 32'hAA);
        tick();
        reset = 0; idle_writes();
        #1;
        check("post_reset_busy1", {31'b0, busy1}, 32'h0);
        check("post_reset_stall", {31'b0, stall}, 32'h0);
        check("post_reset_rd1", rd1, 32'h0);
        a1 = 3;
        #1;
        check("post_reset_r3", rd1, 32'h0);

        // Late writeback after reset still writes normally.
        we1 = 1; wa1 = 7; wd1 = 32'hC0DE;
        tick();
        idle_writes();
        a1 = 7;
        #1;
        check("late_wb_r7", rd1, 32'hC0DE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised successor to the pipeline's 3-read/1-write register file.
- Holds NREGS general registers; the all-ones address reads the externally supplied PC (r15) value.
- Adds a second write port, write-to-read bypass, synchronous clear on reset and a per-register pending-write scoreboard.
- Sits in the decode stage: feeds operand muxes and raises busy flags for the hazard unit.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 4, register address width.
- NREGS, 2**ADDR_W-1, number of physical registers. Addresses 0..NREGS-1. Address 2**ADDR_W-1 (PC_ADDR) is not stored.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- we1  in  1  write enable, port 1 (writeback ALU/load result).
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- we2  in  1  write enable, port 2 (base-register update).
- wa2  in  ADDR_W  write address, port 2.
- wd2  in  DATA_W  write data, port 2.
- pc_in  in  DATA_W  value returned for PC_ADDR reads.
- a1, a2, a3  in  ADDR_W each  read addresses.
- rd1, rd2, rd3  out  DATA_W each  read data.
- iss_en  in  1  an instruction with a register destination issues this cycle.
- iss_wa  in  ADDR_W  destination of the issuing instruction.
- busy1, busy2, busy3  out  1 each  operand N has a pending, not-yet-bypassable write.
- stall  out  1  OR of busy1..busy3.

Behaviour:
- Reset (sampled at posedge clk, reset=1):
  - all registers := 0; pending[] := 0.
  - Write and issue inputs are ignored that cycle.
  - After reset: rdN = 0 for non-PC addresses, busyN = 0, stall = 0.
- Writes (at posedge, reset=0):
  - weK && waK != PC_ADDR: rf[waK] := wdK.
  - Writes to PC_ADDR are silently dropped.
  - we1 and we2 to the same address: port 1 wins.
- Reads are combinational, zero-cycle latency. Priority per read port N:
  - aN == PC_ADDR: pc_in.
  - else we1 && wa1 == aN: wd1 (bypass).
  - else we2 && wa2 == aN: wd2 (bypass).
  - else rf[aN].
  - Bypass applies even while reset=1. Stored data still clears at the edge.
- Scoreboard, NREGS pending bits, updated at posedge when reset=0:
  - clear pending[waK] for each weK with waK != PC_ADDR;
  - then set pending[iss_wa] if iss_en && iss_wa != PC_ADDR.
  - Set and clear of the same register in one cycle: set wins (new producer in flight).
  - iss_en for an already-pending register: stays set, no counting (single outstanding producer per register is guaranteed by the issue logic).
- busyN = (aN != PC_ADDR) && pending[aN] && !(we1 && wa1 == aN) && !(we2 && wa2 == aN).
  - The same-cycle write satisfies the read through the bypass, so no stall is raised.
- stall = busy1 | busy2 | busy3. Purely combinational; no registered outputs.
- Out-of-range address (aN >= NREGS and != PC_ADDR): only possible when NREGS < 2**ADDR_W-1. Reads 0, busy 0, writes and issues ignored.
- Reset mid-operation clears all pending bits. In-flight writebacks arriving later still write normally.

Test Plan:
- Reset, then read every address with pc_in=32'h0000_0100 → rd=0 for r0..r14, rd=32'h100 for address 15; busy=0, stall=0.
- we1=1, wa1=3, wd1=32'hDEAD_BEEF with a1=3 in the same cycle → rd1=32'hDEADBEEF combinationally. Next cycle with we1=0 → rd1 still 32'hDEADBEEF.
- we1 and we2 both to r5 (wd1=32'h1, wd2=32'h2) → rd on r5 = 32'h1 that cycle and after the edge. we2 alone to r6 with wd2=32'h7 → r6 = 32'h7.
- we1=1, wa1=15, wd1=32'hFFFF_FFFF → no register changes; a2=15 returns pc_in (not wd1); busy2=0.
- iss_en=1, iss_wa=4, then a1=4 on following cycles:
  - busy1=1, stall=1 until the cycle with we1=1, wa1=4, wd1=32'h55;
  - that cycle: busy1=0, rd1=32'h55;
  - next cycle: busy1=0.
- In one cycle: iss_en=1, iss_wa=7 and we2=1, wa2=7 → next cycle busy on r7 = 1. Then assert reset → pending cleared, busy=0, r7 reads 0.
